// File: rtl/completion_arbiter.sv
// rtl/completion_arbiter.sv - round-robin merge of execution-unit results onto one registered completion bus
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   per-unit result handshake; in_ready is combinational, at most one bit set
//   in_rs_id              per-unit producing reservation-station ID
//   in_reg_addr           per-unit destination GPR
//   in_result             per-unit result value
//   in_cr0_xer            per-unit CR0/XER update
//   out_valid / out_ready completion bus handshake
//   out_unit              index of the unit whose result sits in the output register
//   out_rs_id, out_reg_addr, out_result, out_cr0_xer   registered result fields

package completion_arbiter_pkg;
   typedef struct packed {
      logic [3:0] cr0;   // lt, gt, eq, so
      logic       so;
      logic       ov;
      logic       ca;
   } cond_exception_t;
endpackage

module completion_arbiter
   import completion_arbiter_pkg::*;
#(
   parameter int UNITS       = 4,
   parameter int RS_ID_WIDTH = 5
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [UNITS-1:0]                        in_valid,
   output logic [UNITS-1:0]                        in_ready,
   input  logic [UNITS-1:0][RS_ID_WIDTH-1:0]       in_rs_id,
   input  logic [UNITS-1:0][4:0]                   in_reg_addr,
   input  logic [UNITS-1:0][31:0]                  in_result,
   input  cond_exception_t [UNITS-1:0]             in_cr0_xer,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic [$clog2(UNITS)-1:0]                out_unit,
   output logic [RS_ID_WIDTH-1:0]                  out_rs_id,
   output logic [4:0]                              out_reg_addr,
   output logic [31:0]                             out_result,
   output cond_exception_t                         out_cr0_xer
);

   localparam int UW = $clog2(UNITS);

   logic [UW-1:0] rr_ptr;
   logic [UW-1:0] grant_idx;
   logic [UW-1:0] next_ptr;
   logic          grant_any;
   logic          can_load;
   logic          load;
   int            idx;

   // Gating with rst keeps in_ready low while reset is asserted, so no unit
   // believes its result was taken while the output register is being cleared.
   assign can_load = rst && (!out_valid || out_ready);
   assign load     = can_load && grant_any;

   // Rotating priority search starting at rr_ptr, wrapping UNITS-1 -> 0.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      idx       = 0;
      for (int k = 0; k < UNITS; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= UNITS) idx = idx - UNITS;
         if (!grant_any && in_valid[UW'(idx)]) begin
            grant_any = 1'b1;
            grant_idx = UW'(idx);
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (load) in_ready[grant_idx] = 1'b1;
   end

   // The unit just served drops to lowest priority.
   assign next_ptr = (grant_idx == UW'(UNITS - 1)) ? '0 : grant_idx + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid    <= 1'b0;
         out_unit     <= '0;
         out_rs_id    <= '0;
         out_reg_addr <= '0;
         out_result   <= '0;
         out_cr0_xer  <= '0;
         rr_ptr       <= '0;
      end else if (load) begin
         // Covers both loading an empty slot and back-to-back replacement of
         // a result being drained this cycle.
         out_valid    <= 1'b1;
         out_unit     <= grant_idx;
         out_rs_id    <= in_rs_id[grant_idx];
         out_reg_addr <= in_reg_addr[grant_idx];
         out_result   <= in_result[grant_idx];
         out_cr0_xer  <= in_cr0_xer[grant_idx];
         rr_ptr       <= next_ptr;
      end else if (out_ready) begin
         // Drain with nothing to replace it; data fields keep their last value.
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_completion_arbiter.sv
// tb/tb_completion_arbiter.sv - randomized bench with behavioural model and per-unit scoreboard for completion_arbiter
`timescale 1ns/1ps
module tb_completion_arbiter;
   import completion_arbiter_pkg::*;

   localparam int UNITS = 4;
   localparam int RSW   = 5;
   localparam int UW    = 2;

   logic                         clk = 1'b0;
   logic                         rst = 1'b0;
   logic [UNITS-1:0]             in_valid = '0;
   logic [UNITS-1:0]             in_ready;
   logic [UNITS-1:0][RSW-1:0]    in_rs_id = '0;
   logic [UNITS-1:0][4:0]        in_reg_addr = '0;
   logic [UNITS-1:0][31:0]       in_result = '0;
   cond_exception_t [UNITS-1:0]  in_cr0_xer = '0;
   logic                         out_valid;
   logic                         out_ready = 1'b0;
   logic [UW-1:0]                out_unit;
   logic [RSW-1:0]               out_rs_id;
   logic [4:0]                   out_reg_addr;
   logic [31:0]                  out_result;
   cond_exception_t              out_cr0_xer;

   completion_arbiter #(.UNITS(UNITS), .RS_ID_WIDTH(RSW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs_id(in_rs_id), .in_reg_addr(in_reg_addr),
      .in_result(in_result), .in_cr0_xer(in_cr0_xer),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_unit(out_unit), .out_rs_id(out_rs_id),
      .out_reg_addr(out_reg_addr), .out_result(out_result),
      .out_cr0_xer(out_cr0_xer)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Per-unit result content is a function of (unit, sequence number), so the
   // scoreboard can recognise exactly which result came out.
   function automatic logic [RSW-1:0] gen_rs(input int u, input int s);
      return RSW'(u * 7 + s);
   endfunction
   function automatic logic [4:0] gen_reg(input int u, input int s);
      return 5'(s * 3 + u);
   endfunction
   function automatic logic [31:0] gen_res(input int u, input int s);
      return {8'(u), 8'h5A, 16'(s)};
   endfunction
   function automatic cond_exception_t gen_cx(input int u, input int s);
      return cond_exception_t'(7'(s + u));
   endfunction

   // First valid unit in the order ptr, ptr+1, ... modulo UNITS; -1 if none.
   function automatic int pick(input int ptr, input logic [UNITS-1:0] v);
      for (int k = 0; k < UNITS; k++) begin
         int u = (ptr + k) % UNITS;
         if (v[UW'(u)]) return u;
      end
      return -1;
   endfunction

   // Behavioural model: one result slot plus the priority pointer.
   logic             m_valid;
   logic [UW-1:0]    m_unit;
   logic [RSW-1:0]   m_rs;
   logic [4:0]       m_reg;
   logic [31:0]      m_res;
   cond_exception_t  m_cx;
   int               m_ptr;
   int               mg;
   logic             m_can;
   logic [UNITS-1:0] exp_ready;
   int               granted_unit;

   always_comb begin
      mg        = pick(m_ptr, in_valid);
      m_can     = rst && (!m_valid || out_ready);
      exp_ready = '0;
      if (m_can && mg >= 0) exp_ready[UW'(mg)] = 1'b1;
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_valid      <= 1'b0;
         m_unit       <= '0;
         m_rs         <= '0;
         m_reg        <= '0;
         m_res        <= '0;
         m_cx         <= '0;
         m_ptr        <= 0;
         granted_unit <= -1;
      end else if (m_can && mg >= 0) begin
         m_valid      <= 1'b1;
         m_unit       <= UW'(mg);
         m_rs         <= in_rs_id[UW'(mg)];
         m_reg        <= in_reg_addr[UW'(mg)];
         m_res        <= in_result[UW'(mg)];
         m_cx         <= in_cr0_xer[UW'(mg)];
         m_ptr        <= (mg + 1) % UNITS;
         granted_unit <= mg;
      end else begin
         if (out_ready) m_valid <= 1'b0;
         granted_unit <= -1;
      end
   end

   // Source side: each unit holds its current result until it is granted.
   int          src_seq[UNITS];
   logic        src_valid[UNITS];
   logic        ovr_en = 1'b0;
   logic        sb_on  = 1'b0;
   int          sb_next[UNITS];
   int          wait_cnt[UNITS];
   int          cu;

   initial begin
      for (int u = 0; u < UNITS; u++) begin
         src_seq[u]   = 0;
         src_valid[u] = 1'b0;
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      chk("out_valid",    32'(out_valid),    32'(m_valid));
      chk("out_unit",     32'(out_unit),     32'(m_unit));
      chk("out_rs_id",    32'(out_rs_id),    32'(m_rs));
      chk("out_reg_addr", 32'(out_reg_addr), 32'(m_reg));
      chk("out_result",   out_result,        m_res);
      chk("out_cr0_xer",  {25'b0, out_cr0_xer}, {25'b0, m_cx});
      chk("in_ready",     32'(in_ready),     32'(exp_ready));
      if (!sb_on) begin
         for (int u = 0; u < UNITS; u++) begin
            sb_next[u]  = src_seq[u];
            wait_cnt[u] = 0;
         end
      end else begin
         if (out_valid && out_ready) begin
            cu = int'(out_unit);
            chk("sb_order", out_result, gen_res(cu, sb_next[cu]));
            sb_next[cu]++;
         end
         if (in_ready != '0) begin
            for (int u = 0; u < UNITS; u++) begin
               if (in_valid[UW'(u)]) begin
                  if (in_ready[UW'(u)]) wait_cnt[u] = 0;
                  else begin
                     wait_cnt[u]++;
                     chk("starve_bound", 32'(wait_cnt[u] <= UNITS - 1), 32'd1);
                  end
               end
            end
         end
      end
   end

   task automatic drive_inputs();
      for (int u = 0; u < UNITS; u++) begin
         in_valid[UW'(u)]    = src_valid[u];
         in_rs_id[UW'(u)]    = gen_rs(u, src_seq[u]);
         in_reg_addr[UW'(u)] = gen_reg(u, src_seq[u]);
         in_result[UW'(u)]   = gen_res(u, src_seq[u]);
         in_cr0_xer[UW'(u)]  = gen_cx(u, src_seq[u]);
      end
      if (ovr_en) begin
         in_rs_id[2]    = 5'd5;
         in_reg_addr[2] = 5'd7;
         in_result[2]   = 32'h0000_002A;
      end
   endtask

   // One clock: retire the unit the model saw granted, raise requested valids,
   // set out_ready. Returns 2 time units after the edge.
   task automatic cycle(input logic [UNITS-1:0] want, input logic rdy);
      @(posedge clk);
      #1;
      if (granted_unit >= 0) begin
         src_seq[granted_unit]++;
         src_valid[granted_unit] = 1'b0;
      end
      for (int u = 0; u < UNITS; u++)
         if (want[UW'(u)]) src_valid[u] = 1'b1;
      drive_inputs();
      out_ready = rdy;
      #1;
   endtask

   logic [UW-1:0] held_unit;
   logic [31:0]   held_res;

   initial begin
      // Reset with every unit requesting.
      rst = 1'b0;
      repeat (2) cycle(4'hF, 1'b1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_out_result", out_result,    32'd0);
      rst = 1'b1;
      #1;
      chk("rst_release_grant0", 32'(in_ready), 32'b0001);

      // Round robin, all valid, consumer always ready.
      cycle(4'hF, 1'b1);
      chk("rr_unit0", 32'(out_unit), 32'd0);
      cycle(4'hF, 1'b1);
      chk("rr_unit1", 32'(out_unit), 32'd1);
      cycle(4'hF, 1'b1);
      chk("rr_unit2", 32'(out_unit), 32'd2);
      cycle(4'hF, 1'b1);
      chk("rr_unit3", 32'(out_unit), 32'd3);
      cycle(4'hF, 1'b1);
      chk("rr_wrap_unit0", 32'(out_unit), 32'd0);
      chk("rr_valid", 32'(out_valid), 32'd1);

      // Backpressure: this edge still sees ready=1 and loads unit1.
      cycle(4'hF, 1'b0);
      held_unit = out_unit;
      held_res  = out_result;
      chk("bp_loaded_unit1", 32'(held_unit), 32'd1);
      repeat (5) begin
         cycle(4'hF, 1'b0);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_unit_hold", 32'(out_unit), 32'(held_unit));
         chk("bp_res_hold", out_result, held_res);
      end
      cycle(4'hF, 1'b1);
      chk("bp_release_hold", 32'(out_unit), 32'd1);
      cycle(4'hF, 1'b1);
      chk("bp_no_bubble_valid", 32'(out_valid), 32'd1);
      chk("bp_no_bubble_unit2", 32'(out_unit), 32'd2);

      // Drain the remaining held requests (3, 0, 1, 2).
      repeat (6) cycle(4'h0, 1'b1);
      chk("drain_valid", 32'(out_valid), 32'd0);

      // Sparse: serve unit3 once so the pointer lands on 0, then again.
      cycle(4'b1000, 1'b1);
      cycle(4'h0, 1'b1);
      chk("sparse_first_unit3", 32'(out_unit), 32'd3);
      cycle(4'h0, 1'b1);
      cycle(4'b1000, 1'b1);
      chk("sparse_ready3", 32'(in_ready), 32'b1000);
      cycle(4'h0, 1'b1);
      chk("sparse_unit3", 32'(out_unit), 32'd3);
      cycle(4'b1001, 1'b1);
      chk("sparse_ptr_wrapped", 32'(in_ready), 32'b0001);
      repeat (3) cycle(4'h0, 1'b1);

      // Single result from unit2 with fixed fields.
      ovr_en = 1'b1;
      cycle(4'b0100, 1'b1);
      chk("single_ready2", 32'(in_ready), 32'b0100);
      cycle(4'h0, 1'b1);
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_unit", 32'(out_unit), 32'd2);
      chk("single_rs_id", 32'(out_rs_id), 32'd5);
      chk("single_reg", 32'(out_reg_addr), 32'd7);
      chk("single_result", out_result, 32'h0000_002A);
      ovr_en = 1'b0;
      cycle(4'h0, 1'b1);
      chk("single_drained", 32'(out_valid), 32'd0);

      // Random traffic with scoreboard.
      sb_on = 1'b1;
      repeat (10000) cycle(UNITS'($urandom), 1'($urandom_range(0, 3) != 0));
      repeat (20) cycle(4'h0, 1'b1);
      for (int u = 0; u < UNITS; u++)
         chk("sb_all_delivered", 32'(sb_next[u]), 32'(src_seq[u]));
      chk("final_idle", 32'(out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
